// File: rtl/cla_seq_pkg.sv
// cla_seq_pkg: shared FSM encodings and beat-counter width for the multiword CLA sequencer.
package cla_seq_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;
  function automatic int cla_seq_cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction
endpackage

// File: rtl/cla_multiword_seq_cla.sv
// cla_multiword_seq_cla: combinational WIDTH-bit carry-lookahead adder (parallel-prefix carries).
module cla_multiword_seq_cla #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             ci_i,
  output logic [WIDTH-1:0] s_o,
  output logic             co_o
);
  localparam int L = $clog2(WIDTH);
  logic [L:0][WIDTH-1:0] g, p;
  logic [WIDTH-1:0] prop;
  assign prop = a_i ^ b_i;
  // Carry-in folds into bit 0's generate so the prefix tree yields every carry directly.
  assign g[0] = (a_i & b_i) | {{(WIDTH-1){1'b0}}, prop[0] & ci_i};
  assign p[0] = prop;
  for (genvar k = 0; k < L; k++) begin : g_lvl
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i >= (1 << k)) begin : g_mrg
        assign g[k+1][i] = g[k][i] | (p[k][i] & g[k][i-(1<<k)]);
        assign p[k+1][i] = p[k][i] & p[k][i-(1<<k)];
      end else begin : g_pass
        assign g[k+1][i] = g[k][i];
        assign p[k+1][i] = p[k][i];
      end
    end
  end
  if (WIDTH > 1) begin : g_sum
    assign s_o = prop ^ {g[L][WIDTH-2:0], ci_i};
  end else begin : g_sum1
    assign s_o = prop ^ ci_i;
  end
  assign co_o = g[L][WIDTH-1];
endmodule

// File: rtl/cla_multiword_seq.sv
// cla_multiword_seq: streams NUM_WORDS*WIDTH-bit add (or sub with CLA_SEQ_SUB_EN) through one CLA, LSW first.
// Define CLA_SEQ_SUB_EN to add the sub_i port and subtraction support.
module cla_multiword_seq
  import cla_seq_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int NUM_WORDS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
`ifdef CLA_SEQ_SUB_EN
  input  logic             sub_i,
`endif
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_word_i,
  input  logic [WIDTH-1:0] b_word_i,
  output logic             out_valid_o,
  output logic             out_last_o,
  output logic [WIDTH-1:0] s_word_o,
  output logic             carry_out_o,
  output logic             overflow_o,
  output logic             busy_o,
  output logic             done_o
);
  localparam int CNT_W = cla_seq_cnt_w(NUM_WORDS);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] s_q, s_d, b_eff, sum;
  logic sub_q, sub_d, carry_q, carry_d, vld_q, vld_d, last_q, last_d;
  logic cout_q, cout_d, ovf_q, ovf_d, co, go, accept, last;
  cla_multiword_seq_cla #(.WIDTH(WIDTH)) u_cla (
    .a_i (a_word_i),
    .b_i (b_eff),
    .ci_i(carry_q),
    .s_o (sum),
    .co_o(co)
  );
  assign go     = (state_q == S_IDLE) && start_i;
  assign accept = (state_q == S_RUN) && in_valid_i;
  assign last   = cnt_q == CNT_W'(NUM_WORDS - 1);
  assign b_eff  = sub_q ? ~b_word_i : b_word_i;
`ifdef CLA_SEQ_SUB_EN
  assign sub_d = go ? sub_i : sub_q;
`else
  assign sub_d = 1'b0;
`endif
  always_comb begin
    state_d = state_q == S_IDLE ? (start_i ? S_RUN : S_IDLE) :
              state_q == S_RUN  ? ((accept && last) ? S_DONE : S_RUN) : S_IDLE;
    carry_d = go ? sub_d : accept ? co : carry_q;
    cnt_d   = go ? '0 : accept ? cnt_q + 1'b1 : cnt_q;
    s_d     = accept ? sum : s_q;
    vld_d   = accept;
    last_d  = accept && last;
    cout_d  = (accept && last) ? co : cout_q;
    ovf_d   = (accept && last) ? ((a_word_i[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_word_i[WIDTH-1])) : ovf_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      s_q     <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end
  assign in_ready_o  = state_q == S_RUN;
  assign busy_o      = state_q != S_IDLE;
  assign done_o      = state_q == S_DONE;
  assign out_valid_o = vld_q;
  assign out_last_o  = last_q;
  assign s_word_o    = s_q;
  assign carry_out_o = cout_q;
  assign overflow_o  = ovf_q;
endmodule

// File: tb/tb_cla_multiword_seq.sv
// tb_cla_multiword_seq: directed plus random wide add/sub runs checked against plain 65-bit arithmetic.
module tb_cla_multiword_seq;
  localparam int W = 16, N = 4, OW = W * N;
  typedef logic [OW:0] wide_t;
  logic clk = 1'b0, rst = 1'b1, start_i = 1'b0, sub_i = 1'b0, in_valid_i = 1'b0;
  logic [W-1:0] a_word_i = '0, b_word_i = '0, s_word_o;
  logic in_ready_o, out_valid_o, out_last_o, carry_out_o, overflow_o, busy_o, done_o;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  cla_multiword_seq #(.WIDTH(W), .NUM_WORDS(N)) dut (
    .clk(clk), .rst(rst), .start_i(start_i),
`ifdef CLA_SEQ_SUB_EN
    .sub_i(sub_i),
`endif
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .a_word_i(a_word_i), .b_word_i(b_word_i),
    .out_valid_o(out_valid_o), .out_last_o(out_last_o), .s_word_o(s_word_o),
    .carry_out_o(carry_out_o), .overflow_o(overflow_o), .busy_o(busy_o), .done_o(done_o)
  );
  task automatic chk(input string tag, input wide_t obs, input wide_t exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_idle_zero(input string tag);
    chk({tag, "_in_ready"}, wide_t'(in_ready_o), '0);
    chk({tag, "_out_valid"}, wide_t'(out_valid_o), '0);
    chk({tag, "_out_last"}, wide_t'(out_last_o), '0);
    chk({tag, "_busy"}, wide_t'(busy_o), '0);
    chk({tag, "_done"}, wide_t'(done_o), '0);
    chk({tag, "_carry_out"}, wide_t'(carry_out_o), '0);
    chk({tag, "_overflow"}, wide_t'(overflow_o), '0);
    chk({tag, "_s_word"}, wide_t'(s_word_o), '0);
  endtask
  // One full operation; gap_at/gap_len insert idle beats, rst_after aborts after that many words.
  task automatic op(input logic [OW-1:0] a, input logic [OW-1:0] b, input logic s,
                    input int gap_at, input int gap_len, input bit rgap, input int rst_after);
    wide_t full;
    logic signed [OW:0] sx;
    int gl;
    full = {1'b0, a} + {1'b0, s ? ~b : b} + wide_t'(s);
    sx = s ? $signed({a[OW-1], a}) - $signed({b[OW-1], b}) : $signed({a[OW-1], a}) + $signed({b[OW-1], b});
    @(negedge clk);
    start_i = 1'b1; sub_i = s; in_valid_i = 1'b1;
    a_word_i = W'($urandom); b_word_i = W'($urandom);
    @(negedge clk);
    start_i = 1'b0; in_valid_i = 1'b0;
    chk("start_word_ignored", wide_t'(out_valid_o), '0);
    chk("run_in_ready", wide_t'(in_ready_o), wide_t'(1));
    chk("run_busy", wide_t'(busy_o), wide_t'(1));
    for (int k = 0; k < N; k++) begin
      gl = (k == gap_at) ? gap_len : rgap ? int'($urandom_range(0, 2)) : 0;
      repeat (gl) begin
        in_valid_i = 1'b0; a_word_i = W'($urandom); b_word_i = W'($urandom);
        @(negedge clk);
        chk("gap_out_valid", wide_t'(out_valid_o), '0);
      end
      in_valid_i = 1'b1; a_word_i = a[k*W +: W]; b_word_i = b[k*W +: W];
      start_i = (k == 1); sub_i = (k == 1) ? ~s : s;
      @(negedge clk);
      in_valid_i = 1'b0; start_i = 1'b0; sub_i = s;
      chk("out_valid", wide_t'(out_valid_o), wide_t'(1));
      chk("s_word", wide_t'(s_word_o), wide_t'(full[k*W +: W]));
      chk("out_last", wide_t'(out_last_o), wide_t'(k == N - 1));
      chk("done", wide_t'(done_o), wide_t'(k == N - 1));
      if (k + 1 == rst_after) begin
        #2 rst = 1'b1;
        #1 chk_idle_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        chk("post_rst_busy", wide_t'(busy_o), '0);
        return;
      end
    end
    chk("carry_out", wide_t'(carry_out_o), wide_t'(full[OW]));
    chk("overflow", wide_t'(overflow_o), wide_t'(sx[OW] ^ sx[OW-1]));
    @(negedge clk);
    chk("post_done", wide_t'(done_o), '0);
    chk("post_busy", wide_t'(busy_o), '0);
    chk("post_out_valid", wide_t'(out_valid_o), '0);
    chk("held_carry_out", wide_t'(carry_out_o), wide_t'(full[OW]));
    chk("held_overflow", wide_t'(overflow_o), wide_t'(sx[OW] ^ sx[OW-1]));
  endtask
  initial begin
    logic [OW-1:0] ra, rb;
    logic rs;
    #12 chk_idle_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, -1, 0, 1'b0, -1);
    op({OW{1'b1}}, {OW{1'b1}}, 1'b0, -1, 0, 1'b0, -1);
    op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, -1, 0, 1'b0, -1);
    op(64'h1234_FFFF_FFFF_FFFF, 64'h0000_0000_0001_0001, 1'b0, 2, 3, 1'b0, -1);
    op(64'hDEAD_BEEF_0123_4567, 64'h0F0F_F0F0_AAAA_5555, 1'b0, -1, 0, 1'b0, 2);
    op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, -1, 0, 1'b0, -1);
`ifdef CLA_SEQ_SUB_EN
    op(64'd5, 64'd7, 1'b1, -1, 0, 1'b0, -1);
    op(64'h8000_0000_0000_0000, 64'h1, 1'b1, 1, 2, 1'b0, -1);
`endif
    repeat (10) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
`ifdef CLA_SEQ_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      op(ra, rb, rs, -1, 0, 1'b1, -1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
